// File: rtl/result_bcd_converter_if.sv
// Result/BCD stream bundle: ALU result in, packed BCD digits out.
// slave = converter side, master = producer/consumer side.
interface result_bcd_converter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_DIGITS = 5
);
    logic [DATA_WIDTH-1:0]   i_result;
    logic                    i_error;
    logic                    i_signed;
    logic                    i_valid;
    logic                    o_ready;
    logic [4*NUM_DIGITS-1:0] o_bcd;
    logic                    o_negative;
    logic                    o_error;
    logic                    o_valid;
    logic                    i_ready;

    modport slave (
        input  i_result,
        input  i_error,
        input  i_signed,
        input  i_valid,
        output o_ready,
        output o_bcd,
        output o_negative,
        output o_error,
        output o_valid,
        input  i_ready
    );

    modport master (
        output i_result,
        output i_error,
        output i_signed,
        output i_valid,
        input  o_ready,
        input  o_bcd,
        input  o_negative,
        input  o_error,
        input  o_valid,
        output i_ready
    );
endinterface

// File: rtl/result_bcd_converter.sv
// Sequential double-dabble converter: ALU result -> sign + packed BCD.
// Optional leading-zero blanking with RESULT_BCD_BLANK_EN.
module result_bcd_converter #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_DIGITS = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    result_bcd_converter_if.slave  bus
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_WIDTH - 1);

`ifdef RESULT_BCD_BLANK_EN
    localparam logic [BCD_W-1:0] ERR_BCD = '1;
`else
    localparam logic [BCD_W-1:0] ERR_BCD = '0;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [BCD_W-1:0]      acc_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  neg_q;
    logic [BCD_W-1:0]      bcd_q;
    logic                  out_neg_q;
    logic                  out_err_q;

    logic                  in_neg;
    logic [DATA_WIDTH-1:0] in_mag;
    logic [BCD_W-1:0]      acc_adj;
    logic [BCD_W+DATA_WIDTH-1:0] shifted;
    logic [BCD_W-1:0]      acc_next;
    logic [DATA_WIDTH-1:0] shift_next;
    logic [BCD_W-1:0]      bcd_fmt;
`ifdef RESULT_BCD_BLANK_EN
    logic                  lead;
`endif

    assign in_neg = bus.i_signed & bus.i_result[DATA_WIDTH-1];
    assign in_mag = in_neg ? (~bus.i_result + DATA_WIDTH'(1))
                           : bus.i_result;

    // Add 3 to every digit that would overflow past 9 after the shift
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5)
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
    end

    assign shifted    = {acc_adj, shift_q} << 1;
    assign acc_next   = shifted[BCD_W+DATA_WIDTH-1:DATA_WIDTH];
    assign shift_next = shifted[DATA_WIDTH-1:0];

    // Final digit formatting: optional blanking of leading zeros
    always_comb begin
        bcd_fmt = acc_next;
`ifdef RESULT_BCD_BLANK_EN
        lead = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (lead && acc_next[4*i +: 4] == 4'd0)
                bcd_fmt[4*i +: 4] = 4'hF;
            else
                lead = 1'b0;
        end
`endif
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            bcd_q     <= '0;
            out_neg_q <= 1'b0;
            out_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.i_valid) begin
                        acc_q <= '0;
                        if (bus.i_error) begin
                            neg_q     <= 1'b0;
                            bcd_q     <= ERR_BCD;
                            out_neg_q <= 1'b0;
                            out_err_q <= 1'b1;
                            state_q   <= OUTPUT;
                        end else begin
                            shift_q <= in_mag;
                            neg_q   <= in_neg;
                            cnt_q   <= CNT_LOAD;
                            state_q <= CONVERT;
                        end
                    end
                end
                CONVERT: begin
                    acc_q   <= acc_next;
                    shift_q <= shift_next;
                    cnt_q   <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        bcd_q     <= bcd_fmt;
                        out_neg_q <= neg_q;
                        out_err_q <= 1'b0;
                        state_q   <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (bus.i_ready)
                        state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_ready    = (state_q == IDLE);
    assign bus.o_valid    = (state_q == OUTPUT);
    assign bus.o_bcd      = bcd_q;
    assign bus.o_negative = out_neg_q;
    assign bus.o_error    = out_err_q;

endmodule

// File: doc/result_bcd_converter.md
Name: result_bcd_converter

Overview:
- Downstream consumer of the ALU result stream.
- Accepts one result word, with its error flag and a signed/unsigned mode bit, over a valid-ready handshake.
- Converts the magnitude to packed BCD digits with a sign flag using a sequential double-dabble (shift-and-add-3), one bit per cycle.
- Presents the digits to the display/formatter stage over a second valid-ready handshake.

Parameters:
- DATA_WIDTH, 16, width of the incoming result word.
- NUM_DIGITS, 5, number of BCD output digits. Must satisfy 10^NUM_DIGITS > 2^DATA_WIDTH - 1.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- i_result  input  DATA_WIDTH  result word from the ALU.
- i_error  input  1  ALU error flag (e.g. divide by zero).
- i_signed  input  1  1: interpret i_result as 2's complement; 0: unsigned.
- i_valid  input  1  input valid.
- o_ready  output  1  input ready.
- o_bcd  output  4*NUM_DIGITS  packed BCD; digit 0 (ones) in bits [3:0].
- o_negative  output  1  result was negative.
- o_error  output  1  error passthrough.
- o_valid  output  1  output valid.
- i_ready  input  1  output ready from downstream.

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low.
- Reset (asynchronous): state IDLE; o_bcd=0, o_negative=0, o_error=0, o_valid=0. o_ready=1 as soon as reset deasserts. Shift register, BCD accumulator and bit counter are cleared.
- Reset mid-conversion or mid-output: operation is abandoned, no output is produced, block returns to IDLE.
- States: IDLE, CONVERT, OUTPUT.
- o_ready=1 only in IDLE. o_valid=1 only in OUTPUT. Both decode directly from the state register.
- IDLE, on i_valid && o_ready:
  - Latch i_error.
  - neg = i_signed && i_result[DATA_WIDTH-1].
  - mag = neg ? (~i_result + 1) : i_result, at DATA_WIDTH bits, treated as unsigned. 0x8000 yields magnitude 32768.
  - If i_error: clear the BCD accumulator, set neg=0, go directly to OUTPUT (o_valid one cycle after acceptance).
  - Otherwise: clear the accumulator, load mag into the shift register, load the bit counter with DATA_WIDTH-1, go to CONVERT.
- CONVERT, each cycle:
  - Add 3 to every accumulator digit >= 5.
  - Shift {accumulator, shift register} left by 1.
  - Decrement the counter.
  - When the counter is 0, the cycle's result is final: go to OUTPUT.
  - Exactly DATA_WIDTH cycles in CONVERT. o_valid rises DATA_WIDTH+1 cycles after the accepting edge.
  - Inputs are ignored during CONVERT.
- o_bcd, o_negative and o_error are registered. They update only on entry to OUTPUT and hold stable while o_valid=1.
- OUTPUT: hold until o_valid && i_ready, then go to IDLE.
  - Outputs retain their last value after the handshake (o_valid=0).
  - A new input is not accepted in the same cycle as the output handshake; o_ready rises the following cycle.
- Zero input: result is all-zero digits with o_negative=0, including signed zero.
- Illegal or unused state encodings return to IDLE.

Optional Feature:
- Macro: RESULT_BCD_BLANK_EN.
- When defined: on entry to OUTPUT, every leading zero digit above digit 0 is replaced with 4'hF (blank code). Digit 0 is never blanked. Error results output all digits 4'hF, including digit 0.
- When undefined: raw BCD with leading zeros. Error results output all zeros.
- Latency is identical in both builds.

Test Plan:
- Unsigned 12345 (0x3039), i_signed=0, i_ready=1 -> o_bcd=0x12345, o_negative=0, o_valid 17 cycles after acceptance, single-cycle valid.
- i_result=0xFFFF, i_signed=0 -> o_bcd=0x65535, o_negative=0. Same word with i_signed=1 -> o_bcd=0x00001, o_negative=1 (blank build: 0xFFFF1).
- i_result=0x8000, i_signed=1 -> o_bcd=0x32768, o_negative=1. i_result=0, i_signed=1 -> o_bcd=0, o_negative=0.
- i_error=1, i_result=0x1234 -> o_error=1, o_negative=0, o_bcd=0 (blank build 0xFFFFF), o_valid one cycle after acceptance.
- Backpressure: i_ready=0 for 10 cycles in OUTPUT -> o_valid, o_bcd and o_negative stable, o_ready=0, new i_valid ignored. On release: handshake, o_ready=1 the next cycle, next word converted correctly.
- Assert rst_n low at CONVERT cycle 7 of 999 -> outputs and o_valid zero immediately. After release, o_ready=1, no stale output appears, and a new conversion of 42 gives 0x00042.
